event_uart_tx: RTL and testbench

Buffered serial event reporter for the heart-model harness. It takes single-cycle event strobes, each carrying an 8-bit event header and a 32-bit beat counter. Events are queued in a small FIFO and each one is sent as a 5-byte 8N1 UART frame on TxD. The block sits between the header/go event logic and the GPIO tx pin. Events that arrive while a frame is in flight are queued rather than lost.

---
 rtl/event_uart_tx_if.sv | 25 ++
 rtl/event_uart_tx.sv | 159 +++++++++++++++
 tb/tb_event_uart_tx.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_uart_tx_if.sv
// Event strobe in, UART line and status out, for the buffered event reporter.
interface event_uart_tx_if #(
    parameter int ADDR_W = 2
);
    logic              go;
    logic [7:0]        header;
    logic [31:0]       counter;
    logic              TxD;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   fifo_count;

    // Event logic side: drives strobes, watches the line and status.
    modport master (
        output go, header, counter,
        input  TxD, busy, done, overflow, fifo_count
    );

    // Reporter side.
    modport slave (
        input  go, header, counter,
        output TxD, busy, done, overflow, fifo_count
    );
endinterface

// File: rtl/event_uart_tx.sv
// Buffered serial event reporter: queues {header, counter} events and sends
// each as five 8N1 bytes (header first, then counter MSB to LSB) on TxD.
module event_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    event_uart_tx_if.slave bus
);

    localparam int                  TIMER_W      = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0]  TIMER_RELOAD = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]     COUNT_FULL   = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [39:0]          mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]      count_q;
    logic [39:0]          frame_q;
    logic [7:0]           byte_q;
    logic [2:0]           bit_idx_q;
    logic [2:0]           byte_idx_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 overflow_q;
    logic                 busy_d;
    logic                 full, push, pop, timer_zero;

    // A pop on the same edge never frees a slot for the push, so full is
    // judged on the registered occupancy alone.
    assign full       = (count_q == COUNT_FULL);
    assign push       = bus.go && !full;
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign timer_zero = (timer_q == '0);

    // Event storage written on accepted strobes.
    // NOTE: the storage array has no reset; clearing the pointers and count
    // is enough to discard queued events, and a plain array maps to RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {bus.header, bus.counter};
    end

    // Queue pointers, occupancy and the drop indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            overflow_q <= bus.go && full;
        end
    end

    // FSM state register.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and line-level decode for the current state.
    // NOTE: defaults come first so no path leaves an output unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b1;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (count_q != '0) state_d = LOAD;
            end
            LOAD: state_d = START;
            START: begin
                tx_d = 1'b0;
                if (timer_zero) state_d = DATA;
            end
            DATA: begin
                tx_d = byte_q[bit_idx_q];
                if (timer_zero && bit_idx_q == 3'd7) state_d = STOP;
            end
            STOP: begin
                if (timer_zero) begin
                    if (byte_idx_q == 3'd4) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timer, bit/byte indices, frame shifter and registered line outputs.
    // TxD is registered so the pin never glitches on state decode; that
    // register is what puts the first start-bit fall three edges after go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            frame_q    <= '0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            done_q <= done_d;

            // Reload on every state change and every bit boundary, so each
            // bit lasts exactly CLKS_PER_BIT cycles with no drift.
            if (state_d != state_q || timer_zero) timer_q <= TIMER_RELOAD;
            else                                  timer_q <= timer_q - 1'b1;

            if (pop) begin
                frame_q    <= mem[rd_ptr_q];
                byte_idx_q <= '0;
            end

            if (state_q == LOAD) begin
                byte_q  <= frame_q[39:32];
                frame_q <= {frame_q[31:0], 8'h00};
            end

            if (state_q == START)                   bit_idx_q <= '0;
            else if (state_q == DATA && timer_zero) bit_idx_q <= bit_idx_q + 1'b1;

            if (state_q == STOP && timer_zero && byte_idx_q != 3'd4)
                byte_idx_q <= byte_idx_q + 1'b1;
        end
    end

    assign bus.TxD        = tx_q;
    assign bus.busy       = busy_d;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_event_uart_tx.sv
// Self-checking bench for event_uart_tx: three instances (4, 2 and 5 clocks
// per bit), a scoreboard of expected frames, and a sample-exact line model.
module tb_event_uart_tx;

    logic clk;
    logic rst_n;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt4    = 0;
    int ovf_cnt4     = 0;

    logic [39:0] sb_q [$];

    event_uart_tx_if #(.ADDR_W(2)) bus4 ();
    event_uart_tx_if #(.ADDR_W(2)) bus2 ();
    event_uart_tx_if #(.ADDR_W(2)) bus5 ();

    event_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );
    event_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4), .ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );
    event_uart_tx #(.CLKS_PER_BIT(5), .FIFO_DEPTH(4), .ADDR_W(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the main instance.
    always @(negedge clk) begin
        if (bus4.done)     done_cnt4 <= done_cnt4 + 1;
        if (bus4.overflow) ovf_cnt4  <= ovf_cnt4 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic txd_of(input int k);
        case (k)
            2:       return bus2.TxD;
            5:       return bus5.TxD;
            default: return bus4.TxD;
        endcase
    endfunction

    function automatic logic done_of(input int k);
        case (k)
            2:       return bus2.done;
            5:       return bus5.done;
            default: return bus4.done;
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            2:       return bus2.busy;
            5:       return bus5.busy;
            default: return bus4.busy;
        endcase
    endfunction

    // Expected line level at sample i after the start-bit fall: per byte a
    // start bit, 8 data bits LSB first, a stop bit, then one extra high cycle
    // between bytes.
    function automatic logic model_bit(input logic [39:0] f, input int cpb, input int i);
        int          slot, off, b, j;
        logic [39:0] sh;
        logic [7:0]  byte_v;
        slot   = 10 * cpb + 1;
        b      = i / slot;
        off    = i % slot;
        sh     = f >> (8 * (4 - b));
        byte_v = sh[7:0];
        if (off < cpb) return 1'b0;
        if (off < 9 * cpb) begin
            j = (off - cpb) / cpb;
            return byte_v[j];
        end
        return 1'b1;
    endfunction

    task automatic drive(input int k, input logic g, input logic [7:0] h, input logic [31:0] c);
        case (k)
            2: begin bus2.go = g; bus2.header = h; bus2.counter = c; end
            5: begin bus5.go = g; bus5.header = h; bus5.counter = c; end
            default: begin bus4.go = g; bus4.header = h; bus4.counter = c; end
        endcase
    endtask

    // Present one strobe for the next rising edge; returns on the following
    // falling edge. Accepted events go to the scoreboard.
    task automatic send(input int k, input logic [7:0] h, input logic [31:0] c, input bit accept);
        if (accept) sb_q.push_back({h, c});
        drive(k, 1'b1, h, c);
        @(negedge clk);
    endtask

    task automatic release_go(input int k);
        drive(k, 1'b0, 8'h00, 32'h0);
    endtask

    // Wait for the start-bit fall, then compare every sample of the frame
    // against the model and check that done pulses only at its last sample.
    task automatic rx_frame(input int k, input int cpb, input int exp_lat, input string name);
        logic [39:0] exp_f;
        logic [39:0] dec;
        logic        got, want;
        int          lat, n, first_bad, slot, off, b;
        bit          bad, done_ok;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (txd_of(k) !== 1'b0 && lat < 3000);
        tests_run++;
        if (txd_of(k) !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s start_bit: got no start bit after %0d cycles, required a frame", name, lat);
            return;
        end
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s scoreboard: got an unexpected frame, required none", name);
            return;
        end
        exp_f = sb_q.pop_front();
        if (exp_lat >= 0) begin
            tests_run++;
            if (lat !== exp_lat) begin
                tests_failed++;
                $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, exp_lat);
            end
        end
        n         = 50 * cpb + 4;
        slot      = 10 * cpb + 1;
        bad       = 1'b0;
        done_ok   = 1'b1;
        first_bad = -1;
        dec       = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            got  = txd_of(k);
            want = model_bit(exp_f, cpb, i);
            b    = i / slot;
            off  = i % slot;
            if (off >= cpb && off < 9 * cpb && ((off - cpb) % cpb) == cpb / 2)
                dec[8 * (4 - b) + (off - cpb) / cpb] = got;
            if (got !== want && !bad) begin
                bad       = 1'b1;
                first_bad = i;
            end
            if (done_of(k) !== (i == n - 1)) done_ok = 1'b0;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL %s waveform: got bytes %010h (first bad sample %0d), required %010h",
                     name, dec, first_bad, exp_f);
        end
        tests_run++;
        if (!done_ok) begin
            tests_failed++;
            $display("FAIL %s done_pulse: got done misplaced in frame, required one pulse at frame end", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        release_go(4);
        release_go(2);
        release_go(5);
        @(negedge clk);
        @(negedge clk);
        tests_run += 7;
        if (bus4.TxD !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b, required 1", bus4.TxD); end
        if (bus4.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", bus4.busy); end
        if (bus4.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, required 0", bus4.done); end
        if (bus4.overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b, required 0", bus4.overflow); end
        if (bus4.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d, required 0", bus4.fifo_count); end
        if (bus2.TxD !== 1'b1) begin tests_failed++; $display("FAIL reset_txd2: got %b, required 1", bus2.TxD); end
        if (bus5.TxD !== 1'b1) begin tests_failed++; $display("FAIL reset_txd5: got %b, required 1", bus5.TxD); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int d0;
        d0 = done_cnt4;
        send(4, 8'h01, 32'h1234_5678, 1'b1);
        release_go(4);
        rx_frame(4, 4, 3, "single");
        tests_run++;
        if (bus4.busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after: got %b, required 0", bus4.busy); end
        @(negedge clk);
        tests_run += 2;
        if (bus4.done !== 1'b0) begin tests_failed++; $display("FAIL single_done_width: got %b, required 0", bus4.done); end
        if (done_cnt4 - d0 !== 1) begin tests_failed++; $display("FAIL single_done_count: got %0d, required 1", done_cnt4 - d0); end
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [2:0] exp_cnt [3];
        exp_cnt = '{3'd1, 3'd1, 3'd2};
        d0 = done_cnt4;
        send(4, 8'h02, 32'hA1B2_C3D4, 1'b1);
        tests_run++;
        if (bus4.fifo_count !== exp_cnt[0]) begin tests_failed++; $display("FAIL b2b_count0: got %0d, required %0d", bus4.fifo_count, exp_cnt[0]); end
        send(4, 8'h04, 32'h0F0F_0F0F, 1'b1);
        tests_run++;
        if (bus4.fifo_count !== exp_cnt[1]) begin tests_failed++; $display("FAIL b2b_count1: got %0d, required %0d", bus4.fifo_count, exp_cnt[1]); end
        send(4, 8'h05, 32'h8000_0001, 1'b1);
        release_go(4);
        tests_run++;
        if (bus4.fifo_count !== exp_cnt[2]) begin tests_failed++; $display("FAIL b2b_count2: got %0d, required %0d", bus4.fifo_count, exp_cnt[2]); end
        rx_frame(4, 4, 1, "b2b_0");
        rx_frame(4, 4, 3, "b2b_1");
        rx_frame(4, 4, 3, "b2b_2");
        @(negedge clk);
        tests_run++;
        if (done_cnt4 - d0 !== 3) begin tests_failed++; $display("FAIL b2b_done_count: got %0d, required 3", done_cnt4 - d0); end
    endtask

    task automatic test_overflow();
        int d0, o0, falls;
        d0 = done_cnt4;
        o0 = ovf_cnt4;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(4, 8'h10 + 8'(i), 32'hC0DE_0000 + 32'(i), i < 5);
                    if (i == 4) begin
                        tests_run++;
                        if (bus4.fifo_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_full_count: got %0d, required 4", bus4.fifo_count); end
                    end
                end
                release_go(4);
                tests_run += 2;
                if (bus4.fifo_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count_kept: got %0d, required 4", bus4.fifo_count); end
                if (bus4.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_pulse: got %b, required 1", bus4.overflow); end
            end
            begin
                rx_frame(4, 4, 4, "ovf_0");
                for (int i = 1; i < 5; i++) rx_frame(4, 4, 3, $sformatf("ovf_%0d", i));
            end
        join
        falls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus4.TxD !== 1'b1) falls++;
        end
        tests_run += 5;
        if (falls !== 0) begin tests_failed++; $display("FAIL ovf_extra_frame: got %0d low samples, required 0", falls); end
        if (bus4.busy !== 1'b0) begin tests_failed++; $display("FAIL ovf_busy_after: got %b, required 0", bus4.busy); end
        if (bus4.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL ovf_count_after: got %0d, required 0", bus4.fifo_count); end
        if (done_cnt4 - d0 !== 5) begin tests_failed++; $display("FAIL ovf_done_count: got %0d, required 5", done_cnt4 - d0); end
        if (ovf_cnt4 - o0 !== 1) begin tests_failed++; $display("FAIL ovf_pulse_count: got %0d, required 1", ovf_cnt4 - o0); end
    endtask

    task automatic test_same_edge();
        int o0;
        // Push on the pop edge with one event queued: occupancy holds.
        o0 = ovf_cnt4;
        send(4, 8'h21, 32'h1111_2222, 1'b1);
        send(4, 8'h22, 32'h3333_4444, 1'b1);
        release_go(4);
        tests_run++;
        if (bus4.fifo_count !== 3'd1) begin tests_failed++; $display("FAIL same_edge_count: got %0d, required 1", bus4.fifo_count); end
        rx_frame(4, 4, 2, "same_edge_0");
        rx_frame(4, 4, 3, "same_edge_1");
        @(negedge clk);
        tests_run++;
        if (ovf_cnt4 - o0 !== 0) begin tests_failed++; $display("FAIL same_edge_no_ovf: got %0d, required 0", ovf_cnt4 - o0); end
        // Push on the pop edge with the queue full: the push is dropped.
        o0 = ovf_cnt4;
        fork
            begin
                for (int i = 0; i < 5; i++) send(4, 8'h30 + 8'(i), 32'h5A5A_0000 + 32'(i), 1'b1);
                release_go(4);
            end
            rx_frame(4, 4, 4, "full_pop_0");
        join
        send(4, 8'hEE, 32'hDEAD_BEEF, 1'b0);
        release_go(4);
        tests_run += 2;
        if (bus4.fifo_count !== 3'd3) begin tests_failed++; $display("FAIL full_pop_count: got %0d, required 3", bus4.fifo_count); end
        if (bus4.overflow !== 1'b1) begin tests_failed++; $display("FAIL full_pop_ovf: got %b, required 1", bus4.overflow); end
        rx_frame(4, 4, 2, "full_pop_1");
        for (int i = 2; i < 5; i++) rx_frame(4, 4, 3, $sformatf("full_pop_%0d", i));
        @(negedge clk);
        tests_run++;
        if (ovf_cnt4 - o0 !== 1) begin tests_failed++; $display("FAIL full_pop_ovf_count: got %0d, required 1", ovf_cnt4 - o0); end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        send(4, 8'hA5, 32'h0000_0000, 1'b0);
        send(4, 8'h5A, 32'h0000_0000, 1'b0);
        release_go(4);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus4.TxD !== 1'b0 && lat < 3000);
        // Sample 97 after the fall lies in data bit 2 of byte 2 (all zeros).
        repeat (97) @(negedge clk);
        tests_run += 3;
        if (bus4.TxD !== 1'b0) begin tests_failed++; $display("FAIL midrst_pre_txd: got %b, required 0", bus4.TxD); end
        if (bus4.busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre_busy: got %b, required 1", bus4.busy); end
        if (bus4.fifo_count !== 3'd1) begin tests_failed++; $display("FAIL midrst_pre_count: got %0d, required 1", bus4.fifo_count); end
        #1 rst_n = 1'b0;
        #1;
        tests_run += 3;
        if (bus4.TxD !== 1'b1) begin tests_failed++; $display("FAIL midrst_txd: got %b, required 1", bus4.TxD); end
        if (bus4.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b, required 0", bus4.busy); end
        if (bus4.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL midrst_count: got %0d, required 0", bus4.fifo_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(4, 8'h77, 32'hFEDC_BA98, 1'b1);
        release_go(4);
        rx_frame(4, 4, 3, "after_reset");
    endtask

    task automatic test_zero_header();
        int cpbs [3];
        int ks [3];
        cpbs = '{4, 2, 5};
        ks   = '{4, 2, 5};
        for (int i = 0; i < 3; i++) begin
            send(ks[i], 8'h00, 32'hFFFF_FFFF, 1'b1);
            release_go(ks[i]);
            rx_frame(ks[i], cpbs[i], 3, $sformatf("zero_hdr_cpb%0d", cpbs[i]));
            tests_run++;
            if (busy_of(ks[i]) !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_hdr_busy_cpb%0d: got %b, required 0", cpbs[i], busy_of(ks[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_same_edge();
        test_reset_mid_frame();
        test_zero_header();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
